// File: rtl/u_seq_rdiv4_if.sv
// Operand/result handshake bundle for the iterative restoring divider.
// master drives operands and result acceptance; slave is the divider.
interface u_seq_rdiv4_if #(
  parameter int N = 4
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] u_seq_rdiv4_q;
  logic [N-1:0] u_seq_rdiv4_r;
  logic         div_by_zero;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out_valid, u_seq_rdiv4_q, u_seq_rdiv4_r, div_by_zero
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out_valid, u_seq_rdiv4_q, u_seq_rdiv4_r, div_by_zero
  );
endinterface

// File: rtl/u_seq_rdiv4.sv
// Unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// a == q*b + r for b != 0; b == 0 falls out of the algorithm as q = all-ones, r = a.
module u_seq_rdiv4 #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst,
  u_seq_rdiv4_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [N:0]    p;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q_out;
  logic [N-1:0]  r_out;
  logic          dbz;

  logic          accept;
  logic          last;
  logic [N:0]    p_sh;
  logic [N-1:0]  q_sh;
  logic [N:0]    t;
  logic [N:0]    p_nx;
  logic [N-1:0]  q_nx;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (cnt == CW'(N - 1));

  // One restoring step: shift {P,Q} left, trial-subtract D, keep T only if no borrow.
  always_comb begin
    p_sh = {p[N-1:0], q[N-1]};
    q_sh = {q[N-2:0], 1'b0};
    t    = p_sh - {1'b0, d};
    p_nx = p_sh;
    q_nx = q_sh;
    if (!t[N]) begin
      p_nx = t;
      q_nx = q_sh | {{(N-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = RUN;
      RUN:     if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Result registers are separate from the working Q/P so q and r survive the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      q_out <= '0;
      r_out <= '0;
      dbz   <= 1'b0;
    end else begin
      if (accept) begin
        q   <= bus.a;
        d   <= bus.b;
        p   <= '0;
        cnt <= '0;
        dbz <= (bus.b == '0);
      end else if (state == RUN) begin
        p   <= p_nx;
        q   <= q_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          q_out <= q_nx;
          r_out <= p_nx[N-1:0];
        end
      end
    end
  end

  assign bus.u_seq_rdiv4_q = q_out;
  assign bus.u_seq_rdiv4_r = r_out;
  assign bus.div_by_zero   = dbz;
endmodule
